branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It feeds the IF-stage next-PC mux with a predicted next PC. It is trained from ID-stage branch/jump resolution, replacing the fixed "predict not-taken, flush on taken" policy of the 5-stage pipeline. It also keeps saturating branch and misprediction statistics counters.

## Interface
Parameters:
- ADDR_W, 32, PC and target width in bits (≥ 8).
- ENTRIES, 16, number of BTB entries; power of two, ≥ 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width (≥ 1).
- STAT_W, 32, width of statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- lookup_pc_i  in  ADDR_W  IF-stage PC.
- hit_o  out  1  valid entry with matching tag for lookup_pc_i.
- pred_taken_o  out  1  hit_o and counter MSB = 1.
- pred_next_pc_o  out  ADDR_W  stored target if pred_taken_o, else lookup_pc_i + 4.
- upd_valid_i  in  1  one resolved branch/jump this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved instruction.
- upd_is_jump_i  in  1  unconditional jump (always taken).
- upd_taken_i  in  1  actual direction (ignored and treated as 1 when upd_is_jump_i = 1).
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this instruction at IF.
- upd_pred_target_i  in  ADDR_W  pred_next_pc_o captured at IF.
- invalidate_i  in  1  clear all valid bits.
- mispredict_o  out  1  combinational; upd_valid_i and resolved next PC ≠ upd_pred_target_i.
- branch_cnt_o  out  STAT_W  resolved updates counted.
- mispredict_cnt_o  out  STAT_W  mispredictions counted.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[ADDR_W], ctr[CTR_W].
- Lookup is purely combinational from current state. There is no write-through: an update to the same index in the same cycle becomes visible only after the clock edge.
- Resolved next PC = upd_target_i if taken, else upd_pc_i + 4. All additions are modulo 2^ADDR_W.
- Update on upd_valid_i = 1, with taken = upd_taken_i | upd_is_jump_i:
  - Hit (valid and tag match):
    - taken: ctr saturating increment; target ← upd_target_i.
    - not taken: ctr saturating decrement; target unchanged.
    - upd_is_jump_i: ctr ← all ones.
  - Miss and taken: allocate, overwriting any existing entry at that index. Set valid = 1 and tag. Set target = upd_target_i. Set ctr = 2^(CTR_W-1) (weakly taken), or all ones for a jump.
  - Miss and not taken: no change.
- Statistics, on upd_valid_i = 1:
  - branch_cnt_o += 1.
  - mispredict_cnt_o += 1 when mispredict_o = 1.
  - Both saturate at 2^STAT_W − 1 and do not wrap.
- invalidate_i = 1: all valid bits ← 0 at the edge. Any update in the same cycle is discarded for BTB state, but still counted in statistics. Counters and targets are retained and are overwritten at the next allocation.
- A jump whose prediction was correct (hit, target match) does not count as a misprediction.

## Timing
- Reset (async, immediate):
  - all valid = 0; ctr = 2^(CTR_W-1) − 1 (weakly not-taken); targets = 0.
  - branch_cnt_o = mispredict_cnt_o = 0.
  - Resulting outputs: hit_o = 0, pred_taken_o = 0, pred_next_pc_o = lookup_pc_i + 4, mispredict_o follows inputs.
- Lookup latency: 0 cycles (combinational).
- Update latency: 1 cycle. State written at edge N is visible to lookup in cycle N+1.
- Reset asserted mid-operation discards any in-flight update. The first update after deassertion is processed normally.
- One update per cycle maximum; there is no backpressure.
- CTR_W = 1: allocate sets ctr = 1. The counter behaves as a last-outcome bit.

## Test plan
- Reset, lookup_pc_i = 0x100 → hit_o = 0, pred_taken_o = 0, pred_next_pc_o = 0x104. Both stat counters = 0.
- Update pc 0x100 taken, target 0x200, pred_taken 0, pred_target 0x104 → mispredict_o = 1. Next cycle: lookup 0x100 gives hit_o = 1, pred_next_pc_o = 0x200; mispredict_cnt_o = 1, branch_cnt_o = 1.
- Same branch resolved not-taken twice (ENTRIES = 16, CTR_W = 2) → ctr 2→1→0. Lookup gives hit_o = 1, pred_taken_o = 0, pred_next_pc_o = 0x104. Three further taken updates → ctr 3, and a fourth taken update keeps ctr at 3.
- Aliasing: allocate 0x100, then taken update at 0x140 (same index, different tag) → lookup 0x100 misses, lookup 0x140 hits with its target.
- Jump at 0x300 → ctr = 3 on allocate. invalidate_i for one cycle, asserted together with an update at 0x400 → both 0x300 and 0x400 miss afterward; branch_cnt_o still increments.
- Drive mispredict updates until STAT_W = 4 counters reach 15 → both stay at 15 on further updates. Async reset pulse between clock edges → counters read 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters, feeding the IF-stage next-PC mux and
// trained from ID-stage branch/jump resolution. Also keeps saturating
// branch and misprediction statistics.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_next_pc_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_is_jump_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    input  logic              invalidate_i,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispredict_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Counter encodings: all ones, weakly taken (MSB only), weakly not-taken.
    localparam logic [CTR_W-1:0]  CTR_MAX    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK_T = CTR_MAX ^ (CTR_MAX >> 1);
    localparam logic [CTR_W-1:0]  CTR_WEAK_N = CTR_MAX >> 1;
    localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [CTR_W-1:0]  ctr_d    [ENTRIES];

    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_taken;
    logic [ADDR_W-1:0] resolved_pc;

    assign lk_idx  = lookup_pc_i[IDX_W+1:2];
    assign lk_tag  = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

    // Lookup reads only registered state, so same-cycle updates are not forwarded.
    assign hit_o          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o   = hit_o && ctr_q[lk_idx][CTR_W-1];
    assign pred_next_pc_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

    // A jump is always taken regardless of upd_taken_i.
    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_taken    = upd_taken_i | upd_is_jump_i;
    assign resolved_pc  = upd_taken ? upd_target_i : upd_pc_i + ADDR_W'(4);
    assign mispredict_o = upd_valid_i && (resolved_pc != upd_pred_target_i);

    // The IF-stage direction guess is implied by the predicted target, so it is not needed here.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken_i;

    // Next BTB contents: invalidate wins over training, otherwise train or allocate the indexed entry.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (invalidate_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_is_jump_i) begin
                    ctr_d[upd_idx] = CTR_MAX;
                end else if (upd_taken_i) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
                    end
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
                end
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target_i;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                ctr_d[upd_idx]    = upd_is_jump_i ? CTR_MAX : CTR_WEAK_T;
            end
        end
    end

    // Statistics counters stick at their maximum instead of wrapping.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd_valid_i) begin
            if (branch_cnt_q != STAT_MAX) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (mispredict_o && (mispredict_cnt_q != STAT_MAX)) begin
                mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
            end
        end
    end

    // State registers; reset leaves every entry invalid and weakly not-taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_N;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            ctr_q            <= ctr_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, multi-cycle reset and
// saturation sequences, and randomized traffic against a behavioural model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        invalidate;

    logic        hit, pred_taken, mispredict;
    logic [31:0] pred_next_pc, branch_cnt, mispredict_cnt;
    logic        hit_s, pred_taken_s, mispredict_s;
    logic [31:0] pred_next_pc_s;
    logic [3:0]  branch_cnt_s, mispredict_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
        .hit_o(hit), .pred_taken_o(pred_taken), .pred_next_pc_o(pred_next_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_jump_i(upd_is_jump),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .invalidate_i(invalidate), .mispredict_o(mispredict),
        .branch_cnt_o(branch_cnt), .mispredict_cnt_o(mispredict_cnt)
    );

    branch_predictor #(.STAT_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
        .hit_o(hit_s), .pred_taken_o(pred_taken_s), .pred_next_pc_o(pred_next_pc_s),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_jump_i(upd_is_jump),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .invalidate_i(invalidate), .mispredict_o(mispredict_s),
        .branch_cnt_o(branch_cnt_s), .mispredict_cnt_o(mispredict_cnt_s)
    );

    // Behavioural model: 16 entries, 2-bit counters as plain integers 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_bcnt, m_mcnt;
    int          m_b4, m_m4;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
        end
        m_bcnt = 0; m_mcnt = 0; m_b4 = 0; m_m4 = 0;
    endtask

    function automatic void modelLookup(input logic [31:0] pc, output logic h,
                                        output logic tk, output logic [31:0] npc);
        int idx;
        idx = int'((pc >> 2) % 32'd16);
        h   = m_valid[idx] && (m_tag[idx] == (pc >> 6));
        tk  = h && (m_ctr[idx] >= 2);
        npc = tk ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic logic modelMisp();
        logic [31:0] resolved;
        resolved = (upd_taken || upd_is_jump) ? upd_target : upd_pc + 32'd4;
        return upd_valid && (resolved != upd_pred_target);
    endfunction

    task automatic modelStep();
        int idx;
        logic tk, h;
        idx = int'((upd_pc >> 2) % 32'd16);
        tk  = upd_taken || upd_is_jump;
        h   = m_valid[idx] && (m_tag[idx] == (upd_pc >> 6));
        if (upd_valid) begin
            if (m_bcnt < 64'd4294967295) m_bcnt++;
            if (m_b4 < 15) m_b4++;
            if (modelMisp()) begin
                if (m_mcnt < 64'd4294967295) m_mcnt++;
                if (m_m4 < 15) m_m4++;
            end
        end
        if (invalidate) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (upd_valid) begin
            if (h) begin
                if (upd_is_jump) m_ctr[idx] = 3;
                else if (upd_taken) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                else m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                if (tk) m_tgt[idx] = upd_target;
            end else if (tk) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = upd_pc >> 6;
                m_tgt[idx]   = upd_target;
                m_ctr[idx]   = upd_is_jump ? 3 : 2;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] lk, input logic uv, input logic [31:0] pc,
                                 input logic j, input logic t, input logic [31:0] tg,
                                 input logic pt, input logic [31:0] ptg, input logic inv);
        lookup_pc = lk; upd_valid = uv; upd_pc = pc; upd_is_jump = j; upd_taken = t;
        upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg; invalidate = inv;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkComb(input string name, input logic eh, input logic et,
                             input logic [31:0] enpc, input logic em);
        checkOutput({name, ".hit"}, 64'(hit), 64'(eh));
        checkOutput({name, ".pred_taken"}, 64'(pred_taken), 64'(et));
        checkOutput({name, ".next_pc"}, 64'(pred_next_pc), 64'(enpc));
        checkOutput({name, ".mispredict"}, 64'(mispredict), 64'(em));
        checkOutput({name, ".hit_s"}, 64'(hit_s), 64'(eh));
        checkOutput({name, ".next_pc_s"}, 64'(pred_next_pc_s), 64'(enpc));
    endtask

    task automatic checkStats(input string name);
        checkOutput({name, ".branch_cnt"}, 64'(branch_cnt), 64'(m_bcnt));
        checkOutput({name, ".mispredict_cnt"}, 64'(mispredict_cnt), 64'(m_mcnt));
        checkOutput({name, ".branch_cnt4"}, 64'(branch_cnt_s), 64'(m_b4));
        checkOutput({name, ".mispredict_cnt4"}, 64'(mispredict_cnt_s), 64'(m_m4));
    endtask

    function automatic logic [31:0] randPc();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h1FF);
    endfunction

    typedef struct {
        logic [31:0] lk;
        logic        uv;
        logic [31:0] pc;
        logic        j;
        logic        t;
        logic [31:0] tg;
        logic        pt;
        logic [31:0] ptg;
        logic        inv;
        logic        eh;
        logic        et;
        logic [31:0] enpc;
        logic        em;
    } vec_t;

    function automatic vec_t mk(logic [31:0] lk, logic uv, logic [31:0] pc, logic j, logic t,
                                logic [31:0] tg, logic pt, logic [31:0] ptg, logic inv,
                                logic eh, logic et, logic [31:0] enpc, logic em);
        vec_t v;
        v.lk = lk; v.uv = uv; v.pc = pc; v.j = j; v.t = t; v.tg = tg; v.pt = pt;
        v.ptg = ptg; v.inv = inv; v.eh = eh; v.et = et; v.enpc = enpc; v.em = em;
        return v;
    endfunction

    vec_t vecs [21];

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        eh, et, ph, ptk;
        logic [31:0] enpc, pnpc, upc;

        //        lookup  uv pc      j  t  target  pt ptarget inv  hit tk next_pc  misp
        vecs[0]  = mk('h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0,  0, 0, 'h104, 0);
        vecs[1]  = mk('h100, 1, 'h100, 0, 1, 'h200, 0, 'h104, 0,  0, 0, 'h104, 1);
        vecs[2]  = mk('h100, 1, 'h100, 0, 0, 'h200, 1, 'h200, 0,  1, 1, 'h200, 1);
        vecs[3]  = mk('h100, 1, 'h100, 0, 0, 'h200, 0, 'h104, 0,  1, 0, 'h104, 0);
        vecs[4]  = mk('h100, 1, 'h100, 0, 1, 'h200, 0, 'h104, 0,  1, 0, 'h104, 1);
        vecs[5]  = mk('h100, 1, 'h100, 0, 1, 'h200, 0, 'h104, 0,  1, 0, 'h104, 1);
        vecs[6]  = mk('h100, 1, 'h100, 0, 1, 'h200, 1, 'h200, 0,  1, 1, 'h200, 0);
        vecs[7]  = mk('h100, 1, 'h100, 0, 1, 'h200, 1, 'h200, 0,  1, 1, 'h200, 0);
        vecs[8]  = mk('h100, 1, 'h100, 0, 0, 'h200, 1, 'h200, 0,  1, 1, 'h200, 1);
        vecs[9]  = mk('h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0,  1, 1, 'h200, 0);
        vecs[10] = mk('h140, 1, 'h140, 0, 1, 'h500, 0, 'h144, 0,  0, 0, 'h144, 1);
        vecs[11] = mk('h100, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0,  0, 0, 'h104, 0);
        vecs[12] = mk('h140, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0,  1, 1, 'h500, 0);
        vecs[13] = mk('h300, 1, 'h300, 1, 0, 'h380, 0, 'h304, 0,  0, 0, 'h304, 1);
        vecs[14] = mk('h300, 1, 'h300, 0, 0, 'h380, 1, 'h380, 0,  1, 1, 'h380, 1);
        vecs[15] = mk('h300, 1, 'h300, 0, 0, 'h380, 1, 'h380, 0,  1, 1, 'h380, 1);
        vecs[16] = mk('h300, 1, 'h300, 1, 0, 'h380, 0, 'h304, 0,  1, 0, 'h304, 1);
        vecs[17] = mk('h300, 1, 'h300, 1, 0, 'h380, 1, 'h380, 0,  1, 1, 'h380, 0);
        vecs[18] = mk('h400, 1, 'h400, 0, 1, 'h480, 0, 'h404, 1,  0, 0, 'h404, 1);
        vecs[19] = mk('h300, 0, 'h300, 0, 1, 'h000, 0, 'h000, 0,  0, 0, 'h304, 0);
        vecs[20] = mk('h400, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0,  0, 0, 'h404, 0);

        // Reset state
        rst = 1'b1;
        applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #3;
        checkComb("reset", 0, 0, 32'h104, 0);
        checkStats("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].lk, vecs[i].uv, vecs[i].pc, vecs[i].j, vecs[i].t,
                          vecs[i].tg, vecs[i].pt, vecs[i].ptg, vecs[i].inv);
            #1;
            checkComb($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].enpc, vecs[i].em);
            checkStats($sformatf("vec%0d", i));
            @(posedge clk);
            modelStep();
        end

        // Reset during an in-flight update discards it; the next update is processed
        @(negedge clk);
        applyStimulus(32'h1000, 1, 32'h1000, 0, 1, 32'h2000, 0, 32'h1004, 0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst.branch_cnt", 64'(branch_cnt), 64'd0);
        checkOutput("midrst.mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        checkOutput("midrst.hit", 64'(hit), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkComb("post_rst_upd", 0, 0, 32'h1004, 1);
        checkStats("post_rst_upd");
        @(posedge clk);
        modelStep();
        @(negedge clk);
        applyStimulus(32'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkComb("post_rst_lookup", 1, 1, 32'h2000, 0);
        checkStats("post_rst_lookup");
        @(posedge clk);
        modelStep();

        // Drive mispredicting updates until the 4-bit counters saturate
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h80, 0, 32'h0, 0);
            #1;
            modelLookup(lookup_pc, eh, et, enpc);
            checkComb("sat", eh, et, enpc, modelMisp());
            checkStats("sat");
            @(posedge clk);
            modelStep();
        end
        @(negedge clk);
        applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("sat.branch_cnt4_is_15", 64'(branch_cnt_s), 64'd15);
        checkOutput("sat.mispredict_cnt4_is_15", 64'(mispredict_cnt_s), 64'd15);
        checkStats("sat_hold");

        // Async reset pulse between clock edges clears the counters immediately
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("pulse.branch_cnt", 64'(branch_cnt), 64'd0);
        checkOutput("pulse.mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        checkOutput("pulse.branch_cnt4", 64'(branch_cnt_s), 64'd0);
        checkOutput("pulse.mispredict_cnt4", 64'(mispredict_cnt_s), 64'd0);
        checkOutput("pulse.hit", 64'(hit), 64'd0);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            upc = randPc();
            modelLookup(upc, ph, ptk, pnpc);
            if ($urandom_range(0, 9) < 7) begin
                applyStimulus(($urandom_range(0, 1) == 0) ? upc : randPc(),
                              $urandom_range(0, 3) != 0, upc, $urandom_range(0, 4) == 0,
                              1'($urandom), randPc(), ptk, pnpc, $urandom_range(0, 63) == 0);
            end else begin
                applyStimulus(($urandom_range(0, 1) == 0) ? upc : randPc(),
                              $urandom_range(0, 3) != 0, upc, $urandom_range(0, 4) == 0,
                              1'($urandom), randPc(), 1'($urandom), randPc(),
                              $urandom_range(0, 63) == 0);
            end
            #1;
            modelLookup(lookup_pc, eh, et, enpc);
            checkComb("rand", eh, et, enpc, modelMisp());
            checkStats("rand");
            @(posedge clk);
            modelStep();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
